// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared load funct3 encodings, FSM states and byte-count decode
package load_pkg;

  localparam logic [2:0] LOAD_B  = 3'b000;
  localparam logic [2:0] LOAD_H  = 3'b001;
  localparam logic [2:0] LOAD_W  = 3'b010;
  localparam logic [2:0] LOAD_BU = 3'b100;
  localparam logic [2:0] LOAD_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } load_state_t;

  // Zero marks an illegal funct3.
  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    case (f3)
      LOAD_B, LOAD_BU: byte_count = 3'd1;
      LOAD_H, LOAD_HU: byte_count = 3'd2;
      LOAD_W:          byte_count = 3'd4;
      default:         byte_count = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of an assembled little-endian load word
module load_extend
  import load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (funct3)
      LOAD_B:  result = {{24{word[7]}}, word[7:0]};
      LOAD_H:  result = {{16{word[15]}}, word[15:0]};
      LOAD_W:  result = word;
      LOAD_BU: result = {24'h0, word[7:0]};
      LOAD_HU: result = {16'h0, word[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/byte_load_unit.sv
// rtl/byte_load_unit.sv - RV32I load executor over a byte-wide synchronous RAM,
// one byte read per access, assembled little-endian and extended for writeback.
module byte_load_unit
  import load_pkg::*;
#(
  parameter int addr_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [addr_width-1:0] addr,
  output logic [addr_width-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [7:0]            mem_data,
  output logic [31:0]           data,
  output logic                  done,
  output logic                  error,
  output logic                  busy
);

  load_state_t           state;
  logic [addr_width-1:0] base;
  logic [2:0]            f3_q;
  logic [2:0]            n_q;
  logic [1:0]            idx;
  logic [31:0]           asm_q;

  logic [31:0]           asm_next;
  logic [31:0]           ext_word;
  logic [1:0]            idx_inc;
  logic [addr_width-1:0] next_addr;
  logic [2:0]            req_count;

  // Assembly including the byte arriving this cycle, so DONE can present it immediately.
  always_comb begin
    asm_next = asm_q;
    case (idx)
      2'd0: asm_next[7:0]   = mem_data;
      2'd1: asm_next[15:8]  = mem_data;
      2'd2: asm_next[23:16] = mem_data;
      default: asm_next[31:24] = mem_data;
    endcase
  end

  assign idx_inc   = idx + 2'd1;
  assign next_addr = base + addr_width'(idx_inc);
  assign req_count = byte_count(funct3);

  load_extend u_extend (
    .word   (asm_next),
    .funct3 (f3_q),
    .result (ext_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      f3_q      <= '0;
      n_q       <= '0;
      idx       <= '0;
      asm_q     <= '0;
      data      <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      done      <= 1'b0;
      error     <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (req_count != 3'd0) begin
              base      <= addr;
              f3_q      <= funct3;
              n_q       <= req_count;
              idx       <= '0;
              asm_q     <= '0;
              mem_addr  <= addr;
              mem_rd_en <= 1'b1;
              state     <= ISSUE;
            end else begin
              data  <= '0;
              done  <= 1'b1;
              error <= 1'b1;
              state <= DONE;
            end
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          asm_q <= asm_next;
          if ({1'b0, idx} == n_q - 3'd1) begin
            data  <= ext_word;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx       <= idx_inc;
            mem_addr  <= next_addr;
            mem_rd_en <= 1'b1;
            state     <= ISSUE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_load_unit.sv
// tb/tb_byte_load_unit.sv - scoreboard bench for byte_load_unit with directed load vectors
module tb_byte_load_unit;
  import load_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_data;
  logic [31:0] data;
  logic        done;
  logic        error;
  logic        busy;

  byte_load_unit #(.addr_width(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .addr      (addr),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_data  (mem_data),
    .data      (data),
    .done      (done),
    .error     (error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_byte = 8'h80;
      32'h0000_0101: mem_byte = 8'h7F;
      32'h0000_0102: mem_byte = 8'h12;
      32'h0000_0103: mem_byte = 8'hF0;
      32'hFFFF_FFFE: mem_byte = 8'h11;
      32'hFFFF_FFFF: mem_byte = 8'h22;
      32'h0000_0000: mem_byte = 8'h33;
      32'h0000_0001: mem_byte = 8'h44;
      default:       mem_byte = 8'hA5;
    endcase
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_data <= mem_byte(mem_addr);

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [31:0] cyc;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] cyc;
  } acc_t;

  resp_t resp_q[$];
  acc_t  acc_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] val);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, val, cyc);
  endtask

  // Monitor: pops expected RAM accesses and responses as the DUT presents them.
  always @(negedge clk) begin
    acc_t  a;
    resp_t r;
    if (mem_rd_en) begin
      if (acc_q.size() == 0) unexpected("rd_unexpected", mem_addr);
      else begin
        a = acc_q.pop_front();
        chk("rd_addr", mem_addr, a.addr);
        chk("rd_cycle", cyc, a.cyc);
      end
    end
    if (done) begin
      if (resp_q.size() == 0) unexpected("done_unexpected", data);
      else begin
        r = resp_q.pop_front();
        chk("resp_data", data, r.data);
        chk("resp_error", error, r.err);
        chk("resp_cycle", cyc, r.cyc);
      end
    end
    if (error && !done) unexpected("error_without_done", 32'(error));
  end

  // Called at a negedge while the DUT is idle; returns at a negedge of the cycle after DONE.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input int nbytes,
                       input logic [31:0] exp_data, input logic exp_err, input int pulse_at);
    int s;
    s = cyc;
    resp_q.push_back('{data: exp_data, err: exp_err, cyc: 32'(s + 2 * nbytes + 1)});
    for (int i = 0; i < nbytes; i++)
      acc_q.push_back('{addr: a + 32'(i), cyc: 32'(s + 1 + 2 * i)});
    start  = 1'b1;
    funct3 = f3;
    addr   = a;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      start = (pulse_at != 0) && (cyc == s + pulse_at);
      if (start) begin
        funct3 = LOAD_B;
        addr   = 32'h0000_0103;
      end
      if (done) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int s;
    rst    = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    addr   = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(LOAD_B,  32'h0000_0100, 1, 32'hFFFF_FF80, 1'b0, 0);
    issue(LOAD_BU, 32'h0000_0100, 1, 32'h0000_0080, 1'b0, 0);
    issue(LOAD_H,  32'h0000_0100, 2, 32'h0000_7F80, 1'b0, 0);
    issue(LOAD_H,  32'h0000_0102, 2, 32'hFFFF_F012, 1'b0, 0);
    issue(LOAD_HU, 32'h0000_0102, 2, 32'h0000_F012, 1'b0, 0);
    issue(LOAD_W,  32'h0000_0100, 4, 32'hF012_7F80, 1'b0, 4);
    issue(LOAD_W,  32'hFFFF_FFFE, 4, 32'h4433_2211, 1'b0, 0);
    issue(LOAD_W,  32'h0000_0101, 4, 32'hA5F0_127F, 1'b0, 0);
    issue(3'b011,  32'h0000_0100, 0, 32'h0000_0000, 1'b1, 0);
    issue(LOAD_B,  32'h0000_0103, 1, 32'hFFFF_FFF0, 1'b0, 0);
    issue(3'b111,  32'h0000_0100, 0, 32'h0000_0000, 1'b1, 0);

    // Reset in cycle 4 of a word load: only the first two reads happen, no response.
    issue(LOAD_HU, 32'h0000_0100, 2, 32'h0000_7F80, 1'b0, 0);
    s = cyc;
    acc_q.push_back('{addr: 32'h0000_0100, cyc: 32'(s + 1)});
    acc_q.push_back('{addr: 32'h0000_0101, cyc: 32'(s + 3)});
    start  = 1'b1;
    funct3 = LOAD_W;
    addr   = 32'h0000_0100;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rd_en", mem_rd_en, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_data", data, 32'h0);
    repeat (12) @(negedge clk);
    issue(LOAD_B, 32'h0000_0101, 1, 32'h0000_007F, 1'b0, 0);

    // rst and start together: start is dropped.
    rst    = 1'b1;
    start  = 1'b1;
    funct3 = LOAD_W;
    addr   = 32'h0000_0100;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", busy, 1'b0);
    chk("rst_start_data", data, 32'h0);
    repeat (10) @(negedge clk);

    chk("resp_q_empty", resp_q.size(), 0);
    chk("acc_q_empty", acc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
